imem_boot_loader: RTL and testbench

Hardware program loader and run controller for the 16-bit single-cycle CPU. It accepts a stream of instruction words over a valid/ready port and writes them into instruction memory through the CPU's external-write path. It then holds the CPU in reset for a programmable number of cycles, releases it, and buffers every value the CPU drives onto its OUT register in a result FIFO. The run ends on HLT or on a cycle timeout. It replaces bench-driven memory loading with a synthesizable, re-runnable sequencer.

---
 rtl/imem_boot_loader.sv | 209 ++++++++++++++++++++
 tb/tb_imem_boot_loader.sv | 424 ++++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/imem_boot_loader.sv
// rtl/imem_boot_loader.sv - program loader, CPU reset sequencer and OUT result FIFO
module imem_boot_loader #(
    parameter int DATA_W    = 16,
    parameter int ADDR_W    = 16,
    parameter int DEPTH     = 64,
    parameter int RST_HOLD  = 9,
    parameter int TIMEOUT   = 1024,
    parameter int OUT_DEPTH = 8
) (
    input  logic              CLK,
    input  logic              clr_n,
    input  logic              start,
    input  logic              load_valid,
    output logic              load_ready,
    input  logic [DATA_W-1:0] load_data,
    input  logic              load_last,
    output logic              instr2memory_en,
    output logic              I_memory_en,
    output logic [ADDR_W-1:0] instr2memory_addr,
    output logic [DATA_W-1:0] instr_in,
    output logic              cpu_clr_n,
    output logic              PC_en,
    input  logic              HLT,
    input  logic              out_strobe,
    input  logic [DATA_W-1:0] OutR_D,
    output logic              res_valid,
    input  logic              res_ready,
    output logic [DATA_W-1:0] res_data,
    output logic              busy,
    output logic              done,
    output logic              timeout,
    output logic              overflow,
    output logic [ADDR_W-1:0] word_count
);

    localparam int WC_W = $clog2(DEPTH) + 1;
    localparam int HC_W = $clog2(RST_HOLD + 1);
    localparam int RC_W = $clog2(TIMEOUT + 1);
    localparam int PW   = (OUT_DEPTH > 1) ? $clog2(OUT_DEPTH) : 1;
    localparam int CW   = $clog2(OUT_DEPTH) + 1;

    localparam logic [2:0] S_IDLE    = 3'd0;
    localparam logic [2:0] S_LOAD    = 3'd1;
    localparam logic [2:0] S_SETTLE  = 3'd2;
    localparam logic [2:0] S_CPU_RST = 3'd3;
    localparam logic [2:0] S_RUN     = 3'd4;
    localparam logic [2:0] S_DONE    = 3'd5;

    logic [2:0]        state_q, state_d;
    logic [WC_W-1:0]   wc_q, wc_d;
    logic [HC_W-1:0]   hold_q, hold_d;
    logic [RC_W-1:0]   run_q, run_d;
    logic              mem_en_q, mem_en_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              timeout_q, timeout_d;
    logic              ovf_q, ovf_d;
    logic [PW-1:0]     rd_q, rd_d;
    logic [PW-1:0]     wr_q, wr_d;
    logic [CW-1:0]     cnt_q, cnt_d;
    logic [DATA_W-1:0] fifo_mem_q [OUT_DEPTH];

    logic start_ok;
    logic push;
    logic pop;
    logic full;
    logic push_ok;

    assign start_ok = start & ((state_q == S_IDLE) | (state_q == S_DONE));
    assign push     = (state_q == S_RUN) & out_strobe;
    assign pop      = res_valid & res_ready;
    assign full     = (cnt_q == CW'(OUT_DEPTH));
    // A full FIFO still accepts a push when the head leaves in the same cycle.
    assign push_ok  = push & (~full | pop);

    always_comb begin
        state_d   = state_q;
        wc_d      = wc_q;
        hold_d    = hold_q;
        run_d     = run_q;
        mem_en_d  = 1'b0;
        addr_d    = addr_q;
        data_d    = data_q;
        timeout_d = timeout_q;
        ovf_d     = ovf_q;
        case (state_q)
            S_IDLE, S_DONE: begin
                if (start) begin
                    state_d   = S_LOAD;
                    wc_d      = '0;
                    timeout_d = 1'b0;
                    ovf_d     = 1'b0;
                end
            end
            S_LOAD: begin
                if (load_valid) begin
                    mem_en_d = 1'b1;
                    addr_d   = ADDR_W'(wc_q);
                    data_d   = load_data;
                    wc_d     = wc_q + WC_W'(1);
                    if (load_last) begin
                        state_d = S_SETTLE;
                    end else if (wc_q == WC_W'(DEPTH - 1)) begin
                        ovf_d   = 1'b1;
                        state_d = S_SETTLE;
                    end
                end
            end
            S_SETTLE: begin
                state_d = S_CPU_RST;
                hold_d  = '0;
            end
            S_CPU_RST: begin
                if (hold_q == HC_W'(RST_HOLD - 1)) begin
                    state_d = S_RUN;
                    run_d   = '0;
                end else begin
                    hold_d = hold_q + HC_W'(1);
                end
            end
            S_RUN: begin
                run_d = run_q + RC_W'(1);
                if (HLT) begin
                    state_d = S_DONE;
                end else if (run_q == RC_W'(TIMEOUT - 1)) begin
                    state_d   = S_DONE;
                    timeout_d = 1'b1;
                end
            end
            default: state_d = S_IDLE;
        endcase
        if (push & full & ~pop) begin
            ovf_d = 1'b1;
        end
    end

    always_comb begin
        rd_d  = rd_q;
        wr_d  = wr_q;
        cnt_d = cnt_q;
        if (start_ok) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (pop) begin
                rd_d = rd_q + PW'(1);
            end
            if (push_ok) begin
                wr_d = wr_q + PW'(1);
            end
            cnt_d = cnt_q + CW'(push_ok) - CW'(pop);
        end
    end

    always_ff @(posedge CLK) begin
        if (!clr_n) begin
            state_q   <= S_IDLE;
            wc_q      <= '0;
            hold_q    <= '0;
            run_q     <= '0;
            mem_en_q  <= 1'b0;
            addr_q    <= '0;
            data_q    <= '0;
            timeout_q <= 1'b0;
            ovf_q     <= 1'b0;
            rd_q      <= '0;
            wr_q      <= '0;
            cnt_q     <= '0;
        end else begin
            state_q   <= state_d;
            wc_q      <= wc_d;
            hold_q    <= hold_d;
            run_q     <= run_d;
            mem_en_q  <= mem_en_d;
            addr_q    <= addr_d;
            data_q    <= data_d;
            timeout_q <= timeout_d;
            ovf_q     <= ovf_d;
            rd_q      <= rd_d;
            wr_q      <= wr_d;
            cnt_q     <= cnt_d;
        end
    end

    // Storage needs no reset: occupancy is tracked by cnt_q alone.
    always_ff @(posedge CLK) begin
        if (push_ok & ~start_ok) begin
            fifo_mem_q[wr_q] <= OutR_D;
        end
    end

    assign load_ready        = (state_q == S_LOAD);
    assign instr2memory_en   = (state_q == S_IDLE) | (state_q == S_LOAD) | (state_q == S_SETTLE);
    assign I_memory_en       = mem_en_q;
    assign instr2memory_addr = addr_q;
    assign instr_in          = data_q;
    assign cpu_clr_n         = (state_q == S_RUN) | (state_q == S_DONE);
    assign PC_en             = (state_q == S_CPU_RST) | (state_q == S_RUN);
    assign res_valid         = (cnt_q != '0);
    assign res_data          = fifo_mem_q[rd_q];
    assign busy              = (state_q == S_LOAD) | (state_q == S_SETTLE) |
                               (state_q == S_CPU_RST) | (state_q == S_RUN);
    assign done              = (state_q == S_DONE);
    assign timeout           = timeout_q;
    assign overflow          = ovf_q;
    assign word_count        = ADDR_W'(wc_q);

endmodule

// File: tb/tb_imem_boot_loader.sv
// tb/tb_imem_boot_loader.sv - self-checking bench for imem_boot_loader
module tb_imem_boot_loader;
    localparam int DATA_W = 16, ADDR_W = 16, DEPTH = 64, RST_HOLD = 9, TIMEOUT = 1024, OUT_DEPTH = 8;

    logic CLK = 1'b0;
    always #5 CLK = ~CLK;

    logic clr_n = 1'b0, start = 1'b0, load_valid = 1'b0, load_last = 1'b0;
    logic HLT = 1'b0, out_strobe = 1'b0, res_ready = 1'b0;
    logic [DATA_W-1:0] load_data = '0, OutR_D = '0;
    logic load_ready, instr2memory_en, I_memory_en, cpu_clr_n, PC_en, res_valid;
    logic busy, done, timeout, overflow;
    logic [ADDR_W-1:0] instr2memory_addr, word_count;
    logic [DATA_W-1:0] instr_in, res_data;

    int errors = 0, checks = 0;

    imem_boot_loader #(.DATA_W(DATA_W), .ADDR_W(ADDR_W), .DEPTH(DEPTH), .RST_HOLD(RST_HOLD),
                       .TIMEOUT(TIMEOUT), .OUT_DEPTH(OUT_DEPTH)) dut (
        .CLK(CLK), .clr_n(clr_n), .start(start), .load_valid(load_valid), .load_ready(load_ready),
        .load_data(load_data), .load_last(load_last), .instr2memory_en(instr2memory_en),
        .I_memory_en(I_memory_en), .instr2memory_addr(instr2memory_addr), .instr_in(instr_in),
        .cpu_clr_n(cpu_clr_n), .PC_en(PC_en), .HLT(HLT), .out_strobe(out_strobe), .OutR_D(OutR_D),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .busy(busy), .done(done),
        .timeout(timeout), .overflow(overflow), .word_count(word_count)
    );

    // Observation logs, written only here and read by the scenario tasks.
    int cyc = 0, rst_cyc = 0, run_cyc = 0, rst_entry_cyc = -1, last_wr_cyc = -1;
    logic in_rst_prev = 1'b0;
    logic [15:0] wr_addr_log[$], wr_data_log[$], pop_log[$], prog_q[$];

    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (I_memory_en) begin
            wr_addr_log.push_back(instr2memory_addr);
            wr_data_log.push_back(instr_in);
            last_wr_cyc <= cyc;
        end
        if (res_valid && res_ready) pop_log.push_back(res_data);
        if (PC_en && !cpu_clr_n) begin
            rst_cyc <= rst_cyc + 1;
            if (!in_rst_prev) rst_entry_cyc <= cyc;
        end
        in_rst_prev <= PC_en && !cpu_clr_n;
        if (PC_en && cpu_clr_n) run_cyc <= run_cyc + 1;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    task automatic tick;
        @(posedge CLK);
        #1;
    endtask

    task automatic do_start;
        start = 1'b1;
        tick;
        start = 1'b0;
    endtask

    task automatic load_program(input bit use_last, input bit gaps, output int n_acc);
        n_acc = 0;
        for (int b = 0; b < 400 && n_acc < prog_q.size(); b++) begin
            if (!load_ready) break;
            load_valid = gaps ? ($urandom_range(0, 3) != 0) : 1'b1;
            load_data  = prog_q[n_acc];
            load_last  = use_last && (n_acc == prog_q.size() - 1);
            if (load_valid) n_acc++;
            tick;
        end
        load_valid = 1'b0;
        load_last  = 1'b0;
    endtask

    task automatic wait_run;
        bit ok = 0;
        for (int i = 0; i < 100; i++) begin
            if (PC_en && cpu_clr_n) begin ok = 1; break; end
            tick;
        end
        checks++;
        if (!ok) begin errors++; $display("FAIL run_wait: got not-running expected RUN state"); end
    endtask

    task automatic test_reset;
        clr_n = 1'b0;
        repeat (3) tick;
        checks++;
        if ({cpu_clr_n, instr2memory_en, PC_en, I_memory_en, load_ready, res_valid, busy, done, timeout, overflow} !== 10'b0100000000) begin
            errors++; $display("FAIL reset_flags: got %b expected 0100000000",
                {cpu_clr_n, instr2memory_en, PC_en, I_memory_en, load_ready, res_valid, busy, done, timeout, overflow});
        end
        checks++;
        if ({word_count, instr2memory_addr, instr_in} !== 48'h0) begin
            errors++; $display("FAIL reset_words: got %h expected 0", {word_count, instr2memory_addr, instr_in});
        end
        clr_n = 1'b1;
        tick;
        checks++;
        if ({busy, load_ready, cpu_clr_n} !== 3'b000) begin
            errors++; $display("FAIL idle_hold: got %b expected 000", {busy, load_ready, cpu_clr_n});
        end
    endtask

    task automatic test_basic;
        int n, wr0, rst0;
        prog_q = '{16'h1025, 16'h0863, 16'hE001};
        wr0 = wr_addr_log.size();
        rst0 = rst_cyc;
        do_start;
        load_program(1, 0, n);
        checks++;
        if (n !== 3) begin errors++; $display("FAIL basic_accepted: got %0d expected 3", n); end
        wait_run;
        checks++;
        if (wr_addr_log.size() - wr0 !== 3) begin
            errors++; $display("FAIL basic_nwrites: got %0d expected 3", wr_addr_log.size() - wr0);
        end else begin
            for (int i = 0; i < 3; i++) begin
                checks++;
                if (wr_addr_log[wr0+i] !== 16'(i) || wr_data_log[wr0+i] !== prog_q[i]) begin
                    errors++; $display("FAIL basic_write%0d: got %h@%0d expected %h@%0d",
                        i, wr_data_log[wr0+i], wr_addr_log[wr0+i], prog_q[i], i);
                end
            end
        end
        checks++;
        if (rst_cyc - rst0 !== RST_HOLD) begin
            errors++; $display("FAIL basic_rst_hold: got %0d expected %0d", rst_cyc - rst0, RST_HOLD);
        end
        checks++;
        if (rst_entry_cyc - last_wr_cyc !== 1) begin
            errors++; $display("FAIL basic_settle: got %0d expected 1", rst_entry_cyc - last_wr_cyc);
        end
        checks++;
        if (word_count !== 16'd3) begin errors++; $display("FAIL basic_word_count: got %0d expected 3", word_count); end
        out_strobe = 1'b1; OutR_D = 16'h6325;
        tick;
        out_strobe = 1'b0; HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if ({done, timeout, PC_en, cpu_clr_n, busy, res_valid} !== 6'b100101) begin
            errors++; $display("FAIL basic_done: got %b expected 100101", {done, timeout, PC_en, cpu_clr_n, busy, res_valid});
        end
        checks++;
        if (res_data !== 16'h6325) begin errors++; $display("FAIL basic_res_data: got %h expected 6325", res_data); end
    endtask

    task automatic test_load_overflow;
        int n, wr0;
        prog_q.delete();
        for (int i = 0; i < DEPTH + 1; i++) prog_q.push_back(16'($urandom));
        wr0 = wr_addr_log.size();
        do_start;
        load_program(0, 0, n);
        checks++;
        if (n !== DEPTH || load_ready !== 1'b0) begin
            errors++; $display("FAIL ovf_accepted: got %0d ready=%b expected %0d ready=0", n, load_ready, DEPTH);
        end
        checks++;
        if (overflow !== 1'b1) begin errors++; $display("FAIL ovf_flag: got %b expected 1", overflow); end
        wait_run;
        checks++;
        if (wr_addr_log.size() - wr0 !== DEPTH) begin
            errors++; $display("FAIL ovf_nwrites: got %0d expected %0d", wr_addr_log.size() - wr0, DEPTH);
        end else begin
            for (int i = 0; i < DEPTH; i++) begin
                checks++;
                if (wr_addr_log[wr0+i] !== 16'(i) || wr_data_log[wr0+i] !== prog_q[i]) begin
                    errors++; $display("FAIL ovf_write%0d: got %h@%0d expected %h@%0d",
                        i, wr_data_log[wr0+i], wr_addr_log[wr0+i], prog_q[i], i);
                end
            end
        end
        checks++;
        if (word_count !== 16'(DEPTH)) begin errors++; $display("FAIL ovf_word_count: got %0d expected %0d", word_count, DEPTH); end
        out_strobe = 1'b1; OutR_D = 16'hBEEF;
        tick;
        out_strobe = 1'b0; HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if ({done, overflow, res_valid} !== 3'b111) begin
            errors++; $display("FAIL ovf_done: got %b expected 111", {done, overflow, res_valid});
        end
    endtask

    task automatic test_start_in_done;
        int n;
        do_start;
        checks++;
        if ({load_ready, busy, done, overflow, timeout, res_valid} !== 6'b110000 || word_count !== 16'd0) begin
            errors++; $display("FAIL restart_clear: got %b wc=%0d expected 110000 wc=0",
                {load_ready, busy, done, overflow, timeout, res_valid}, word_count);
        end
        prog_q = '{16'h0001};
        load_program(1, 0, n);
        wait_run;
        HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if ({done, res_valid} !== 2'b10) begin errors++; $display("FAIL restart_run: got %b expected 10", {done, res_valid}); end
    endtask

    task automatic test_start_in_run;
        int n;
        prog_q = '{16'h1234, 16'h5678};
        do_start;
        load_program(1, 0, n);
        wait_run;
        out_strobe = 1'b1; OutR_D = 16'hAAAA;
        tick;
        out_strobe = 1'b0; start = 1'b1;
        tick;
        start = 1'b0;
        tick;
        checks++;
        if ({busy, PC_en, cpu_clr_n, load_ready, res_valid} !== 5'b11101 || word_count !== 16'd2) begin
            errors++; $display("FAIL run_start_ignored: got %b wc=%0d expected 11101 wc=2",
                {busy, PC_en, cpu_clr_n, load_ready, res_valid}, word_count);
        end
        HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if (done !== 1'b1 || res_data !== 16'hAAAA) begin
            errors++; $display("FAIL run_start_done: got done=%b data=%h expected done=1 data=aaaa", done, res_data);
        end
    endtask

    task automatic test_timeout;
        int n, r0;
        prog_q = '{16'h00FF};
        do_start;
        load_program(1, 0, n);
        wait_run;
        r0 = run_cyc;
        for (int i = 0; i < TIMEOUT + 50; i++) begin
            if (done) break;
            tick;
        end
        checks++;
        if ({done, timeout} !== 2'b11) begin errors++; $display("FAIL timeout_flags: got %b expected 11", {done, timeout}); end
        checks++;
        if (run_cyc - r0 !== TIMEOUT) begin
            errors++; $display("FAIL timeout_cycles: got %0d expected %0d", run_cyc - r0, TIMEOUT);
        end
    endtask

    task automatic test_hlt_at_timeout;
        int n;
        prog_q = '{16'h00FE};
        do_start;
        load_program(1, 0, n);
        wait_run;
        repeat (TIMEOUT - 1) tick;
        checks++;
        if ({PC_en, done} !== 2'b10) begin errors++; $display("FAIL hlt_edge_running: got %b expected 10", {PC_en, done}); end
        HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if ({done, timeout} !== 2'b10) begin errors++; $display("FAIL hlt_edge_flags: got %b expected 10", {done, timeout}); end
    endtask

    task automatic test_fifo_overflow(input bit rdy);
        int n, p0, exp_n;
        prog_q = '{16'h7777};
        do_start;
        load_program(1, 0, n);
        wait_run;
        res_ready = rdy;
        p0 = pop_log.size();
        for (int i = 1; i <= 10; i++) begin
            out_strobe = 1'b1; OutR_D = 16'(i);
            tick;
        end
        out_strobe = 1'b0; HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if (overflow !== !rdy) begin errors++; $display("FAIL fifo_ovf_rdy%0d: got %b expected %b", rdy, overflow, !rdy); end
        res_ready = 1'b1;
        for (int i = 0; i < 12; i++) begin
            if (!res_valid) break;
            tick;
        end
        res_ready = 1'b0;
        exp_n = rdy ? 10 : OUT_DEPTH;
        checks++;
        if (pop_log.size() - p0 !== exp_n || res_valid !== 1'b0) begin
            errors++; $display("FAIL fifo_count_rdy%0d: got %0d valid=%b expected %0d valid=0", rdy, pop_log.size() - p0, res_valid, exp_n);
        end else begin
            for (int i = 0; i < exp_n; i++) begin
                checks++;
                if (pop_log[p0+i] !== 16'(i + 1)) begin
                    errors++; $display("FAIL fifo_word%0d_rdy%0d: got %h expected %h", i, rdy, pop_log[p0+i], i + 1);
                end
            end
        end
    endtask

    task automatic test_mid_reset;
        int n, wr0;
        prog_q = '{16'(($urandom)), 16'(($urandom))};
        do_start;
        load_program(1, 0, n);
        for (int i = 0; i < 20; i++) begin
            if (PC_en && !cpu_clr_n) break;
            tick;
        end
        tick;
        clr_n = 1'b0;
        tick;
        checks++;
        if ({cpu_clr_n, instr2memory_en, PC_en, I_memory_en, load_ready, res_valid, busy, done, timeout, overflow} !== 10'b0100000000
            || {word_count, instr2memory_addr, instr_in} !== 48'h0) begin
            errors++; $display("FAIL midrst_values: got %b %h expected 0100000000 0",
                {cpu_clr_n, instr2memory_en, PC_en, I_memory_en, load_ready, res_valid, busy, done, timeout, overflow},
                {word_count, instr2memory_addr, instr_in});
        end
        clr_n = 1'b1;
        tick;
        wr0 = wr_addr_log.size();
        do_start;
        load_program(1, 0, n);
        wait_run;
        HLT = 1'b1;
        tick;
        HLT = 1'b0;
        checks++;
        if ({done, timeout, overflow} !== 3'b100 || word_count !== 16'd2 || wr_addr_log.size() - wr0 !== 2) begin
            errors++; $display("FAIL midrst_rerun: got %b wc=%0d nw=%0d expected 100 wc=2 nw=2",
                {done, timeout, overflow}, word_count, wr_addr_log.size() - wr0);
        end else begin
            checks++;
            if (wr_addr_log[wr0+1] !== 16'd1 || wr_data_log[wr0+1] !== prog_q[1]) begin
                errors++; $display("FAIL midrst_write1: got %h@%0d expected %h@1", wr_data_log[wr0+1], wr_addr_log[wr0+1], prog_q[1]);
            end
        end
    endtask

    task automatic test_random;
        int n, len, wr0, p0, nrun, wbad;
        logic [15:0] mq[$], exp_pop[$];
        logic ovf_m;
        logic s, r;
        logic [15:0] v;
        for (int it = 0; it < 5; it++) begin
            len = (it == 0) ? DEPTH : $urandom_range(1, DEPTH);
            prog_q.delete();
            for (int i = 0; i < len; i++) prog_q.push_back(16'($urandom));
            wr0 = wr_addr_log.size();
            do_start;
            load_program(1, 1, n);
            wait_run;
            wbad = 0;
            for (int i = 0; i < len && wr0 + i < wr_addr_log.size(); i++)
                if (wr_addr_log[wr0+i] !== 16'(i) || wr_data_log[wr0+i] !== prog_q[i]) wbad++;
            checks++;
            if (n !== len || wr_addr_log.size() - wr0 !== len || wbad !== 0 || word_count !== 16'(len)) begin
                errors++; $display("FAIL rand%0d_load: got acc=%0d nw=%0d bad=%0d wc=%0d expected %0d writes", it, n, wr_addr_log.size() - wr0, wbad, word_count, len);
            end
            mq.delete(); exp_pop.delete(); ovf_m = 1'b0;
            p0 = pop_log.size();
            nrun = $urandom_range(8, 40);
            for (int k = 0; k < nrun; k++) begin
                s = 1'($urandom_range(0, 1));
                r = ($urandom_range(0, 3) == 0);
                v = 16'($urandom);
                out_strobe = s; OutR_D = v; res_ready = r; HLT = (k == nrun - 1);
                if (r && mq.size() > 0) exp_pop.push_back(mq.pop_front());
                if (s) begin
                    if (mq.size() < OUT_DEPTH) mq.push_back(v);
                    else ovf_m = 1'b1;
                end
                tick;
            end
            out_strobe = 1'b0; HLT = 1'b0; res_ready = 1'b1;
            while (mq.size() > 0) exp_pop.push_back(mq.pop_front());
            for (int i = 0; i < OUT_DEPTH + 4; i++) begin
                if (!res_valid) break;
                tick;
            end
            res_ready = 1'b0;
            checks++;
            if ({done, overflow} !== {1'b1, ovf_m}) begin
                errors++; $display("FAIL rand%0d_flags: got %b expected %b", it, {done, overflow}, {1'b1, ovf_m});
            end
            checks++;
            if (pop_log.size() - p0 !== exp_pop.size()) begin
                errors++; $display("FAIL rand%0d_npop: got %0d expected %0d", it, pop_log.size() - p0, exp_pop.size());
            end else begin
                wbad = 0;
                for (int i = 0; i < exp_pop.size(); i++) if (pop_log[p0+i] !== exp_pop[i]) wbad++;
                checks++;
                if (wbad !== 0) begin errors++; $display("FAIL rand%0d_order: got %0d wrong words expected 0", it, wbad); end
            end
        end
    endtask

    initial begin
        test_reset;
        test_basic;
        test_load_overflow;
        test_start_in_done;
        test_start_in_run;
        test_timeout;
        test_hlt_at_timeout;
        test_fifo_overflow(1'b0);
        test_fifo_overflow(1'b1);
        test_mid_reset;
        test_random;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
